z_core_icache: RTL and testbench
================================

# z_core_icache

Direct-mapped, single-word-per-line instruction cache for the Z-Core fetch path. Lookups are purely combinational: hit/miss and instruction data follow `address` within the same cycle, with no clock edge needed. Line fills are synchronous writes driven by the fetch/refill logic after a miss. The block holds no refill state machine; the surrounding fetch unit owns miss handling.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of each cached instruction word.
- `ADDR_WIDTH`, default 32: width of the byte address.
- `CACHE_DEPTH`, default 256: number of lines. Must be a power of two ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` input, 1 bit: clock. All state updates occur on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset. Clears all valid bits.
- `wen` input, 1 bit: fill/write enable, sampled on the rising edge of `clk`.
- `address` input, `ADDR_WIDTH` bits: byte address. Used for both lookup and write.
- `data_in` input, `DATA_WIDTH` bits: fill data, written when `wen` is high.
- `data_out` output, `DATA_WIDTH` bits: cached word at `address` on a hit; 0 on a miss.
- `valid` output, 1 bit: selected line is valid and its tag matches.
- `cache_hit` output, 1 bit: equals `valid`.
- `cache_miss` output, 1 bit: equals `!valid`.

## Operation
- Address split, with `IDX_W = log2(CACHE_DEPTH)`:
  - offset = `address[1:0]`, ignored (word-aligned fetch).
  - index = `address[2 +: IDX_W]`, which is `[9:2]` by default.
  - tag = `address[ADDR_WIDTH-1 : 2+IDX_W]`, which is `[31:10]` by default.
- Storage per line: one valid bit, one tag, and one data word. Data and tag arrays need no reset; valid bits do.
- Lookup, fully combinational from `address` and stored state:
  - `valid` = `valid_bit[index] && (tag_mem[index] == tag)`.
  - `data_out` = `data_mem[index]` when `valid`, else 0.
- Write: on a rising edge with `wen`=1 and `rst`=0, `data_mem[index]` ← `data_in`, `tag_mem[index]` ← tag, and `valid_bit[index]` ← 1.
  - Overwrites unconditionally. Replacement of an aliased line is implicit, since the old tag is lost.
- Reset: on a rising edge with `rst`=1, all valid bits clear. Reset has priority over a simultaneous `wen`, and no write occurs.
- No invalidate-single-line port and no write-back; this is a read-only cache from the core's view.

## Timing
- Read latency is 0 cycles. Outputs settle combinationally after any `address` change, including mid-cycle changes.
- Write-to-read latency is 1 edge. During the cycle in which `wen` is asserted, outputs reflect the pre-write contents. Immediately after the edge, the same `address` reads the new data with `valid`=1.
- Outputs after a reset edge:
  - `valid`=0, `cache_hit`=0, `cache_miss`=1, `data_out`=0, for every address.
  - This persists while `rst` is held high.
- Before the first reset edge, outputs are undefined. The fetch unit must not use them.
- Reset asserted in the middle of a fill sequence discards everything, including the line being written on that edge.
- Back-to-back writes on consecutive edges to different indices are all retained.
- Back-to-back writes to the same index keep the last write.
- `cache_hit` and `cache_miss` are always mutually exclusive and exhaustive.

## Test plan
- Reset, then drive `address`=0x1000 with no clock edge → within 1 ns `cache_miss`=1, `cache_hit`=0, `valid`=0.
- Write 0xDEADBEEF to 0x1000 with `wen` for one edge, then write 0xCAFEBABE to 0x1004. Toggle `address` between them with only 1 ns gaps → `data_out` reads 0xDEADBEEF and 0xCAFEBABE respectively, with `cache_hit`=1 each time.
- Alias: read 0x1400 (same index as 0x1000, different tag) → miss. Write 0x12345678 to 0x1400 → hit returning 0x12345678. Then 0x1000 → miss, with `valid`=0.
- Fill 0x2000 through 0x201C with 0xA0000000+i on 8 consecutive edges. Then read all 8 without clock edges, and change `address` mid-cycle → each returns 0xA0000000+i with a hit.
- Assert `rst` and `wen` on the same edge for 0x3000 → afterwards 0x3000 and all previously filled lines miss, with `data_out`=0.
- Write at index `CACHE_DEPTH-1` (address 0x3FC) and at index 0 (address 0x400) → both hit independently, confirming no index wrap or overlap.

Source files
------------

// File: rtl/z_core_icache.sv
// z_core_icache: direct-mapped single-word-per-line instruction cache with combinational lookup
module z_core_icache #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int CACHE_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  cache_hit,
  output logic                  cache_miss
);
  localparam int IDX_W = $clog2(CACHE_DEPTH);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  logic [DATA_WIDTH-1:0]  data_mem [CACHE_DEPTH];
  logic [TAG_W-1:0]       tag_mem  [CACHE_DEPTH];
  logic [CACHE_DEPTH-1:0] valid_bit;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   unused_offset;
  assign idx           = address[2 +: IDX_W];
  assign tag           = address[ADDR_WIDTH-1 -: TAG_W];
  assign unused_offset = ^address[1:0];
  always_ff @(posedge clk) begin
    if (rst) valid_bit <= '0;
    else if (wen) valid_bit[idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wen && !rst) begin
      data_mem[idx] <= data_in;
      tag_mem[idx]  <= tag;
    end
  end
  always_comb begin
    valid      = valid_bit[idx] && (tag_mem[idx] == tag);
    data_out   = valid ? data_mem[idx] : '0;
    cache_hit  = valid;
    cache_miss = !valid;
  end
endmodule

// File: tb/tb_z_core_icache.sv
// tb_z_core_icache: randomized self-checking bench against a word-address reference model
`timescale 1ns/100ps
module tb_z_core_icache;
  logic        clk = 0;
  logic        rst = 1;
  logic        wen = 0;
  logic [31:0] address = 0;
  logic [31:0] data_in = 0;
  logic [31:0] data_out;
  logic        valid, cache_hit, cache_miss;
  int          checks = 0;
  int          failures = 0;
  bit          mv [256];
  logic [29:0] mw [256];
  logic [31:0] md [256];

  z_core_icache dut (
    .clk(clk), .rst(rst), .wen(wen), .address(address), .data_in(data_in),
    .data_out(data_out), .valid(valid), .cache_hit(cache_hit), .cache_miss(cache_miss)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] exp_of(logic [31:0] a);
    int  i = int'((a >> 2) % 256);
    bit  v = mv[i] && (mw[i] == a[31:2]);
    return {v ? md[i] : 32'h0, v, v, !v};
  endfunction

  function automatic logic [34:0] got_now();
    return {data_out, valid, cache_hit, cache_miss};
  endfunction

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 0;
  endtask

  task automatic model_write(logic [31:0] a, logic [31:0] d);
    int i = int'((a >> 2) % 256);
    mv[i] = 1;
    mw[i] = a[31:2];
    md[i] = d;
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    wen = 1;
    @(posedge clk);
    #1;
    wen = 0;
    model_write(a, d);
  endtask

  task automatic test_reset();
    logic [34:0] e;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    address = 32'h1000;
    #1;
    e = exp_of(address);
    checks++;
    if (got_now() !== e || e !== {32'h0, 3'b001}) begin
      failures++;
      $display("FAIL reset_1000 got=%h exp=%h", got_now(), {32'h0, 3'b001});
    end
    for (int k = 0; k < 4; k++) begin
      address = $urandom;
      #1;
      checks++;
      if (got_now() !== {32'h0, 3'b001}) begin
        failures++;
        $display("FAIL reset_rand addr=%h got=%h exp=%h", address, got_now(), {32'h0, 3'b001});
      end
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    do_write(32'h1000, 32'hDEADBEEF);
    do_write(32'h1004, 32'hCAFEBABE);
    for (int k = 0; k < 4; k++) begin
      address = k[0] ? 32'h1004 : 32'h1000;
      #1;
      checks++;
      if (got_now() !== {k[0] ? 32'hCAFEBABE : 32'hDEADBEEF, 3'b110}) begin
        failures++;
        $display("FAIL basic addr=%h got=%h exp=%h", address, got_now(), {k[0] ? 32'hCAFEBABE : 32'hDEADBEEF, 3'b110});
      end
    end
    address = 32'h1003;
    #1;
    checks++;
    if (got_now() !== {32'hDEADBEEF, 3'b110}) begin
      failures++;
      $display("FAIL offset_ignored got=%h exp=%h", got_now(), {32'hDEADBEEF, 3'b110});
    end
  endtask

  task automatic test_alias();
    address = 32'h1400;
    #1;
    checks++;
    if (got_now() !== {32'h0, 3'b001}) begin
      failures++;
      $display("FAIL alias_pre got=%h exp=%h", got_now(), {32'h0, 3'b001});
    end
    do_write(32'h1400, 32'h12345678);
    address = 32'h1400;
    #1;
    checks++;
    if (got_now() !== {32'h12345678, 3'b110}) begin
      failures++;
      $display("FAIL alias_hit got=%h exp=%h", got_now(), {32'h12345678, 3'b110});
    end
    address = 32'h1000;
    #1;
    checks++;
    if (got_now() !== {32'h0, 3'b001}) begin
      failures++;
      $display("FAIL alias_evict got=%h exp=%h", got_now(), {32'h0, 3'b001});
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) do_write(32'h2000 + 32'(4 * k), 32'hA0000000 + 32'(k));
    do_write(32'h2008, 32'hBBBB0001);
    do_write(32'h2008, 32'hA0000002);
    @(negedge clk);
    for (int k = 7; k >= 0; k--) begin
      address = 32'h2000 + 32'(4 * k);
      #0.5;
      checks++;
      if (got_now() !== {32'hA0000000 + 32'(k), 3'b110}) begin
        failures++;
        $display("FAIL burst addr=%h got=%h exp=%h", address, got_now(), {32'hA0000000 + 32'(k), 3'b110});
      end
    end
  endtask

  task automatic test_write_latency();
    @(negedge clk);
    address = 32'h5010;
    data_in = 32'h0BADF00D;
    wen = 1;
    #1;
    checks++;
    if (got_now() !== {32'h0, 3'b001}) begin
      failures++;
      $display("FAIL pre_write got=%h exp=%h", got_now(), {32'h0, 3'b001});
    end
    @(posedge clk);
    #1;
    wen = 0;
    model_write(32'h5010, 32'h0BADF00D);
    checks++;
    if (got_now() !== {32'h0BADF00D, 3'b110}) begin
      failures++;
      $display("FAIL post_write got=%h exp=%h", got_now(), {32'h0BADF00D, 3'b110});
    end
  endtask

  task automatic test_reset_priority();
    logic [31:0] addrs [5] = '{32'h3000, 32'h1400, 32'h2000, 32'h201C, 32'h5010};
    @(negedge clk);
    rst = 1;
    wen = 1;
    address = 32'h3000;
    data_in = 32'h77777777;
    @(posedge clk);
    #1;
    wen = 0;
    model_clear();
    foreach (addrs[k]) begin
      address = addrs[k];
      #1;
      checks++;
      if (got_now() !== {32'h0, 3'b001}) begin
        failures++;
        $display("FAIL rst_prio addr=%h got=%h exp=%h", address, got_now(), {32'h0, 3'b001});
      end
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_boundary();
    do_write(32'h3FC, 32'h11112222);
    do_write(32'h400, 32'h33334444);
    address = 32'h3FC;
    #1;
    checks++;
    if (got_now() !== {32'h11112222, 3'b110}) begin
      failures++;
      $display("FAIL idx_top got=%h exp=%h", got_now(), {32'h11112222, 3'b110});
    end
    address = 32'h400;
    #1;
    checks++;
    if (got_now() !== {32'h33334444, 3'b110}) begin
      failures++;
      $display("FAIL idx_zero got=%h exp=%h", got_now(), {32'h33334444, 3'b110});
    end
    address = 32'h0;
    #1;
    checks++;
    if (got_now() !== {32'h0, 3'b001}) begin
      failures++;
      $display("FAIL idx_zero_tag got=%h exp=%h", got_now(), {32'h0, 3'b001});
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [34:0] e;
    for (int n = 0; n < 300; n++) begin
      a = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      case ($urandom_range(0, 39))
        0: begin
          @(negedge clk);
          rst = 1;
          wen = $urandom_range(0, 1);
          @(posedge clk);
          #1;
          rst = 0;
          wen = 0;
          model_clear();
        end
        1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14: do_write(a, $urandom);
        default: ;
      endcase
      a = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      address = a;
      #1;
      e = exp_of(a);
      checks++;
      if (got_now() !== e) begin
        failures++;
        $display("FAIL random addr=%h got=%h exp=%h", a, got_now(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alias();
    test_back_to_back();
    test_write_latency();
    test_reset_priority();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
